seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one 7-segment bus among NUM_DIGITS digits on a common-anode display.
- Cycles through the digits on a fixed refresh schedule.
- Inserts a dead-time blank between digits to prevent ghosting.
- Double-buffers the digit values so updates only take effect at frame boundaries.
- Sits between the counter/datapath values and the board display pins; includes its own hex decoder.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DIGIT_WIDTH, 4, bits per digit value (hex nibble)
SEGMENT_WIDTH, 7, segment bus width, index 0 = seg a … 6 = seg g
REFRESH_DIV, 100000, clock cycles per digit slot (blank + show)
BLANK_CYCLES, 1000, dead-time cycles at the start of each slot; 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable
load  in  1  capture digits into pending buffer this cycle
digits  in  NUM_DIGITS*DIGIT_WIDTH  digit i = digits[i*DIGIT_WIDTH +: DIGIT_WIDTH]; digit 0 = least significant, rightmost
seg  out  [0:SEGMENT_WIDTH-1]  segment pattern, 1 = lit
an  out  NUM_DIGITS  digit anode selects, active-low (0 = digit on)
digit_idx  out  clog2(NUM_DIGITS)  index of the digit currently owning the bus
frame_done  out  1  one-cycle pulse at end of last digit's SHOW

Behaviour:
- Reset, sampled at posedge clk: state IDLE, an = all 1s, seg = 0, digit_idx = 0, frame_done = 0, pending and active buffers = 0, slot counter = 0.
- FSM states IDLE, BLANK, SHOW.
  - IDLE, en=1: next cycle BLANK, digit_idx=0, active <= pending (frame start).
  - BLANK: an all 1s; seg already driven with the pattern of active[digit_idx]. Lasts exactly BLANK_CYCLES cycles, then SHOW.
  - SHOW: an[digit_idx]=0, all others 1. Lasts exactly REFRESH_DIV-BLANK_CYCLES cycles. Then:
    - digit_idx < NUM_DIGITS-1: digit_idx increments, go to BLANK.
    - digit_idx = NUM_DIGITS-1: frame_done pulses for one cycle (concurrent with the last SHOW cycle), digit_idx wraps to 0, active <= pending, go to BLANK.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- seg is registered; it changes only on BLANK entry, so the bus never switches while an anode is active.
- load=1: pending <= digits next cycle, independent of state. A load coinciding with a frame-boundary transfer is not visible until the next frame; active takes the old pending value.
- en=0 in any state: next cycle IDLE, an all 1s, seg = 0, digit_idx = 0, counter = 0. pending is retained.
- rst asserted mid-slot: same values as power-on reset, including pending = 0.
- Decoder: standard hex 0-F, abcdefg order.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Slot counter width: clog2(REFRESH_DIV). No arithmetic overflow permitted.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit whose value and all more-significant active digits are 0 drives seg = 0 during its SHOW; anode timing is unchanged. Digit 0 is always displayed, so value 0 shows a single "0".
- Undefined: every digit is decoded normally.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_BLANK constant (all zeros)
  - 16-entry hex-to-segment constant table
- One sub-module: hex_seg_decode, combinational DIGIT_WIDTH -> SEGMENT_WIDTH lookup using the package table. Instantiated once on the muxed active digit.

Test Plan:
Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then load digits=16'h1234, en=1 -> per digit: 2 cycles an=1111, then 6 cycles with the matching anode low.
   - an sequence 1110, 1101, 1011, 0111.
   - seg sequence 0110011 (4), 1111001 (3), 1101101 (2), 0110000 (1).
   - frame_done pulses every 32 cycles.
2. Load 16'h5555 mid-frame -> display unchanged until frame_done; next frame all digits show 1011011.
3. Deassert en during a SHOW -> next cycle an=1111, seg=0, digit_idx=0. Reassert en -> BLANK of digit 0 with pending contents.
4. Assert rst during digit 2 SHOW -> all outputs at reset values next cycle; pending cleared; re-enable shows 0 on all digits.
5. Check every SHOW-to-BLANK boundary -> no cycle where an has a 0 while seg differs from the previous cycle; never more than one anode low.
6. With LEADING_ZERO_BLANK_EN, digits=16'h0050 -> digits 3 and 2 seg=0, digit 1 = 1011011, digit 0 = 1111110. digits=0 -> only digit 0 lit, showing "0".

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int unsigned HEX_SEG_W = 7;

  // Pattern driven while no digit is being shown (index 0 = seg a)
  localparam logic [0:HEX_SEG_W-1] SEG_BLANK = '0;

  // Hex nibble to segment pattern, abcdefg order, 1 = lit
  localparam logic [0:HEX_SEG_W-1] HEX_SEG [0:15] = '{
    7'b1111110, // 0
    7'b0110000, // 1
    7'b1101101, // 2
    7'b1111001, // 3
    7'b0110011, // 4
    7'b1011011, // 5
    7'b1011111, // 6
    7'b1110000, // 7
    7'b1111111, // 8
    7'b1111011, // 9
    7'b1110111, // A
    7'b0011111, // b
    7'b1001110, // C
    7'b0111101, // d
    7'b1001111, // E
    7'b1000111  // F
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_seg_decode.sv
// Combinational hex digit to 7-segment pattern lookup.
module hex_seg_decode
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_WIDTH   = 4,
  parameter int SEGMENT_WIDTH = 7
) (
  input  logic [DIGIT_WIDTH-1:0]   value,
  output logic [0:SEGMENT_WIDTH-1] seg
);

  logic [3:0]             nib;
  logic [0:HEX_SEG_W-1]   pat;

  // Table lookup on the low nibble of the digit value
  always_comb begin
    nib = 4'(value);
    pat = HEX_SEG[nib];
  end

  if (SEGMENT_WIDTH <= HEX_SEG_W) begin : g_narrow
    assign seg = pat[0:SEGMENT_WIDTH-1];
  end else begin : g_wide
    assign seg = {pat, {(SEGMENT_WIDTH-HEX_SEG_W){1'b0}}};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES dead time (all anodes
// off, segment bus already settled) followed by SHOW (one anode low).
// Digit values are double-buffered: load fills pending, and pending moves
// to active only at frame start.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_WIDTH   = 4,
  parameter int SEGMENT_WIDTH = 7,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              load,
  input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits,
  output logic [0:SEGMENT_WIDTH-1]          seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [$clog2(NUM_DIGITS)-1:0]     digit_idx,
  output logic                              frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BUF_W = NUM_DIGITS*DIGIT_WIDTH;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [IDX_W-1:0]         idx_n;
  logic [BUF_W-1:0]         pending, active, active_n;
  logic                     xfer;
  logic                     enter_blank;
  logic [DIGIT_WIDTH-1:0]   cur_digit;
  logic [0:SEGMENT_WIDTH-1] dec_seg;
  logic [0:SEGMENT_WIDTH-1] seg_n;
  logic                     blank_sel;

  // Next-state, slot counter and frame-boundary transfer decisions
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = digit_idx;
    xfer        = 1'b0;
    enter_blank = 1'b0;
    frame_done  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n     = BLANK;
          cnt_n       = '0;
          idx_n       = '0;
          xfer        = 1'b1;
          enter_blank = 1'b1;
        end
        BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_n = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_n       = '0;
            state_n     = BLANK;
            enter_blank = 1'b1;
            if (digit_idx == IDX_LAST) begin
              idx_n      = '0;
              xfer       = 1'b1;
              frame_done = 1'b1;
            end else begin
              idx_n = digit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // The segment pattern is latched on BLANK entry, so it is decoded from the
  // values active and digit_idx are about to take, not their current ones.
  always_comb begin
    active_n  = xfer ? pending : active;
    cur_digit = active_n[idx_n*DIGIT_WIDTH +: DIGIT_WIDTH];
  end

  hex_seg_decode #(
    .DIGIT_WIDTH   (DIGIT_WIDTH),
    .SEGMENT_WIDTH (SEGMENT_WIDTH)
  ) u_dec (
    .value (cur_digit),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  lz_acc;

  // zero_above[i]: digit i and every more-significant digit are zero
  always_comb begin
    zero_above = '0;
    lz_acc     = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      lz_acc     = lz_acc & (active_n[(NUM_DIGITS-1-k)*DIGIT_WIDTH +: DIGIT_WIDTH] == '0);
      zero_above = {zero_above[NUM_DIGITS-2:0], lz_acc};
    end
  end

  assign blank_sel = zero_above[idx_n] && (idx_n != '0);
`else
  assign blank_sel = 1'b0;
`endif

  // Final pattern for the upcoming slot
  always_comb begin
    seg_n = blank_sel ? SEGMENT_WIDTH'(SEG_BLANK) : dec_seg;
  end

  // State, counter, buffers and registered segment bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      digit_idx <= '0;
      pending   <= '0;
      active    <= '0;
      seg       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digit_idx <= idx_n;
      if (load) pending <= digits;
      if (xfer) active  <= pending;
      if (!en)              seg <= '0;
      else if (enter_blank) seg <= seg_n;
    end
  end

  // Only the current digit's anode is driven low, and only during SHOW
  always_comb begin
    an = '1;
    if (state == SHOW) an[digit_idx] = 1'b0;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl (4 digits, 8-cycle slots,
// 2-cycle dead time).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int compared = 0;
  int failed   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS    (4),
    .DIGIT_WIDTH   (4),
    .SEGMENT_WIDTH (7),
    .REFRESH_DIV   (8),
    .BLANK_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits     (digits),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // One frame of expected segment patterns (seg[d] = digit d) plus an
  // optional load injected at a given slot/cycle of that frame.
  typedef struct {
    logic [3:0][6:0] seg;
    logic            ld;
    int              ld_s;
    int              ld_c;
    logic [15:0]     ld_val;
  } frame_t;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                         S9 = 7'b1111011, SC = 7'b1001110, SE = 7'b1001111,
                         SOFF = 7'b0000000;

  frame_t     frames [8];
  logic [3:0] an_show [4];

  // Checks one cycle's outputs at the falling edge, then advances to just
  // after the next rising edge so the caller can drive new inputs.
  task automatic expect_cycle(input logic [3:0] ean, input logic [6:0] eseg,
                              input logic [1:0] eidx, input logic efd,
                              input string tag);
    logic [6:0] got_seg;
    @(negedge clk);
    got_seg = seg;
    compared++;
    if (an !== ean) begin
      failed++;
      $display("FAIL %s an: got %b want %b", tag, an, ean);
    end
    compared++;
    if (got_seg !== eseg) begin
      failed++;
      $display("FAIL %s seg: got %b want %b", tag, got_seg, eseg);
    end
    compared++;
    if (digit_idx !== eidx) begin
      failed++;
      $display("FAIL %s digit_idx: got %0d want %0d", tag, digit_idx, eidx);
    end
    compared++;
    if (frame_done !== efd) begin
      failed++;
      $display("FAIL %s frame_done: got %b want %b", tag, frame_done, efd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    expect_cycle(4'b1111, SOFF, 2'd0, 1'b0, tag);
  endtask

  // Walks frame f slot by slot; stop_s/stop_c end it early (inclusive).
  task automatic run_frame(input int f, input int stop_s, input int stop_c);
    bit halt = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (!halt) begin
          if (frames[f].ld && s == frames[f].ld_s && c == frames[f].ld_c) begin
            load   = 1'b1;
            digits = frames[f].ld_val;
          end else begin
            load = 1'b0;
          end
          expect_cycle((c < 2) ? 4'b1111 : an_show[s], frames[f].seg[s],
                       2'(s), (s == 3 && c == 7),
                       $sformatf("f%0d_s%0d_c%0d", f, s, c));
          if (stop_s >= 0 && s == stop_s && c == stop_c) halt = 1;
        end
      end
    end
    load = 1'b0;
  endtask

  // Bus integrity: while any anode is on, exactly one is on and the
  // segment pattern is identical to the previous cycle's.
  logic [6:0] prev_seg = '0;
  always @(negedge clk) begin
    if (an != 4'b1111) begin
      compared++;
      if (seg !== prev_seg || $countones(~an) != 1) begin
        failed++;
        $display("FAIL bus_integrity: an=%b seg=%b prev_seg=%b", an, seg, prev_seg);
      end
    end
    prev_seg = seg;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    an_show[0] = 4'b1110;
    an_show[1] = 4'b1101;
    an_show[2] = 4'b1011;
    an_show[3] = 4'b0111;

    // f0: 1234 displayed
    frames[0] = '{seg: {S1, S2, S3, S4}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
    // f1: still 1234 while 5555 is loaded mid-frame
    frames[1] = '{seg: {S1, S2, S3, S4}, ld: 1'b1, ld_s: 1, ld_c: 3, ld_val: 16'h5555};
    // f2: 5555; E0C8 loaded in the last cycle, coinciding with the transfer
    frames[2] = '{seg: {S5, S5, S5, S5}, ld: 1'b1, ld_s: 3, ld_c: 7, ld_val: 16'hE0C8};
    // f3: boundary load is not visible yet
    frames[3] = '{seg: {S5, S5, S5, S5}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
    // f4: E0C8 (inner zero is never blanked)
    frames[4] = '{seg: {SE, S0, SC, S8}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
    // f5: 6789 after en was cycled
    frames[5] = '{seg: {S6, S7, S8, S9}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
`ifdef LEADING_ZERO_BLANK_EN
    // f6: all zero after reset cleared pending; 0050 loaded mid-frame
    frames[6] = '{seg: {SOFF, SOFF, SOFF, S0}, ld: 1'b1, ld_s: 1, ld_c: 0, ld_val: 16'h0050};
    // f7: 0050
    frames[7] = '{seg: {SOFF, SOFF, S5, S0}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
`else
    frames[6] = '{seg: {S0, S0, S0, S0}, ld: 1'b1, ld_s: 1, ld_c: 0, ld_val: 16'h0050};
    frames[7] = '{seg: {S0, S0, S5, S0}, ld: 1'b0, ld_s: 0, ld_c: 0, ld_val: 16'h0};
`endif

    rst    = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    digits = '0;
    @(posedge clk);
    #1;
    expect_idle("reset_state");
    rst = 1'b0;

    load   = 1'b1;
    digits = 16'h1234;
    expect_idle("idle_load");
    load = 1'b0;
    en   = 1'b1;
    expect_idle("idle_en_rise");

    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    run_frame(2, -1, -1);
    run_frame(3, -1, -1);
    run_frame(4, -1, -1);

    // en dropped during digit 0 SHOW
    run_frame(4, 0, 2);
    en = 1'b0;
    expect_cycle(4'b1110, S8, 2'd0, 1'b0, "en_drop_show");
    load   = 1'b1;
    digits = 16'h6789;
    expect_idle("en_off_1");
    load = 1'b0;
    expect_idle("en_off_2");
    en = 1'b1;
    expect_idle("en_back");
    run_frame(5, -1, -1);

    // reset during digit 2 SHOW
    run_frame(5, 2, 2);
    rst = 1'b1;
    expect_cycle(4'b1011, S7, 2'd2, 1'b0, "rst_in_show");
    rst = 1'b0;
    expect_idle("after_rst");
    run_frame(6, -1, -1);
    run_frame(7, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
